// File: rtl/gpio_db_pkg.sv
// gpio_db_pkg: register offsets and limits shared by the debounced APB GPIO port
// Contents: byte offsets of every mapped register, the pin-count upper bound and
//           an address-decode helper used for the error response.
package gpio_db_pkg;
   localparam int MaxWidth = 32;
   localparam logic [7:0] OFF_DATA    = 8'h00;
   localparam logic [7:0] OFF_DOUT    = 8'h04;
   localparam logic [7:0] OFF_OUTEN   = 8'h08;
   localparam logic [7:0] OFF_INTEN   = 8'h0C;
   localparam logic [7:0] OFF_INTTYPE = 8'h10;
   localparam logic [7:0] OFF_INTPOL  = 8'h14;
   localparam logic [7:0] OFF_INTBOTH = 8'h18;
   localparam logic [7:0] OFF_INTSTAT = 8'h1C;
   localparam logic [7:0] OFF_DBTHR   = 8'h20;
   localparam logic [7:0] OFF_DBEN    = 8'h24;
   localparam logic [7:0] OFF_DSET    = 8'h28;
   localparam logic [7:0] OFF_DCLR    = 8'h2C;
   // Offsets are word aligned by construction, so the map is one contiguous range.
   function automatic logic off_mapped(input logic [7:0] off);
      return off <= OFF_DCLR;
   endfunction
endpackage

// File: rtl/gpio_db_pin.sv
// gpio_db_pin: one pin's synchroniser, debounce filter, edge/level detect and status bit
// Ports: clk/rst        clock and synchronous active-high reset
//        pin_in         asynchronous pad input
//        db_en, db_thr  debounce enable and threshold (0 threshold = bypass)
//        int_en/type/pol/both  interrupt enable, 1=edge, polarity, both-edges
//        clr            write-one-to-clear strobe for this pin's status
//        stable         debounced pin value
//        stat           interrupt status bit
module gpio_db_pin
   import gpio_db_pkg::*;
#(
   parameter int SyncStages = 2,
   parameter int DbWidth    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pin_in,
   input  logic               db_en,
   input  logic [DbWidth-1:0] db_thr,
   input  logic               int_en,
   input  logic               int_type,
   input  logic               int_pol,
   input  logic               int_both,
   input  logic               clr,
   output logic               stable,
   output logic               stat
);
   logic [SyncStages-1:0] sync_q;
   logic [DbWidth-1:0]    cnt;
   logic                  sync, prev, bypass, hit, rise, fall, edge_hit, lvl_hit, set;

   assign sync     = sync_q[SyncStages-1];
   assign bypass   = !db_en || db_thr == '0;
   // Threshold reached on this cycle: the DBTHR-th consecutive differing sample.
   assign hit      = sync != stable && cnt == db_thr - 1'b1;
   assign rise     = stable & ~prev;
   assign fall     = ~stable & prev;
   assign edge_hit = int_both ? rise | fall : int_pol ? rise : fall;
   assign lvl_hit  = int_pol ? stable : ~stable;
   assign set      = int_en & (int_type ? edge_hit : lvl_hit);

   always_ff @(posedge clk)
      if (rst) begin
         sync_q <= '0;
         cnt    <= '0;
         stable <= 1'b0;
         prev   <= 1'b0;
         stat   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], pin_in};
         stable <= bypass || hit ? sync : stable;
         cnt    <= bypass || sync == stable || hit ? '0 : cnt + 1'b1;
         prev   <= stable;
         // A new event outranks a simultaneous clear so no event is ever lost.
         stat   <= set | (stat & ~clr);
      end
endmodule

// File: rtl/apb_gpio_db.sv
// apb_gpio_db: parametrised APB GPIO port with input debounce and edge/level interrupts
// Ports: PCLK, PRESET        clock, synchronous active-high reset
//        PSEL..PWDATA        APB slave request (PADDR is the word address)
//        PRDATA, PREADY      combinational read data, always ready
//        PSLVERR             error on access to an unmapped offset
//        PORTIN              asynchronous pad inputs
//        PORTOUT, PORTEN     pad output value and output enable
//        GPIOINT, COMBINT    registered per-pin interrupts and their OR
module apb_gpio_db
   import gpio_db_pkg::*;
#(
   parameter int PortWidth  = 8,
   parameter int SyncStages = 2,
   parameter int DbWidth    = 8
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   input  logic                 PSEL,
   input  logic [5:0]           PADDR,
   input  logic                 PENABLE,
   input  logic                 PWRITE,
   input  logic [31:0]          PWDATA,
   output logic [31:0]          PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR,
   input  logic [PortWidth-1:0] PORTIN,
   output logic [PortWidth-1:0] PORTOUT,
   output logic [PortWidth-1:0] PORTEN,
   output logic [PortWidth-1:0] GPIOINT,
   output logic                 COMBINT
);
   logic [7:0]           off;
   logic                 acc, wr, rd, unused_pwdata;
   logic [PortWidth-1:0] wd, dout, outen, inten, inttype, intpol, intboth, dben, data, stat;
   logic [DbWidth-1:0]   dbthr;
   logic [31:0]          rdata;

   assign off          = {PADDR, 2'b00};
   assign acc          = PSEL & PENABLE;
   assign wr           = acc & PWRITE;
   assign rd           = acc & ~PWRITE;
   assign wd           = PWDATA[PortWidth-1:0];
   assign unused_pwdata = ^PWDATA;
   assign PREADY       = 1'b1;
   assign PSLVERR      = acc & ~off_mapped(off);
   assign PRDATA       = rd ? rdata : '0;
   assign PORTOUT      = dout;
   assign PORTEN       = outen;

   always_ff @(posedge PCLK)
      if (PRESET) begin
         dout    <= '0;
         outen   <= '0;
         inten   <= '0;
         inttype <= '0;
         intpol  <= '0;
         intboth <= '0;
         dbthr   <= '0;
         dben    <= '0;
         GPIOINT <= '0;
         COMBINT <= 1'b0;
      end else begin
         if (wr && off == OFF_DOUT) dout <= wd;
         if (wr && off == OFF_DSET) dout <= dout | wd;
         if (wr && off == OFF_DCLR) dout <= dout & ~wd;
         if (wr && off == OFF_OUTEN) outen <= wd;
         if (wr && off == OFF_INTEN) inten <= wd;
         if (wr && off == OFF_INTTYPE) inttype <= wd;
         if (wr && off == OFF_INTPOL) intpol <= wd;
         if (wr && off == OFF_INTBOTH) intboth <= wd;
         if (wr && off == OFF_DBTHR) dbthr <= PWDATA[DbWidth-1:0];
         if (wr && off == OFF_DBEN) dben <= wd;
         GPIOINT <= stat & inten;
         COMBINT <= |(stat & inten);
      end

   // Write-only and unmapped offsets fall through to zero.
   always_comb begin
      rdata = '0;
      case (off)
         OFF_DATA:    rdata = 32'(data);
         OFF_DOUT:    rdata = 32'(dout);
         OFF_OUTEN:   rdata = 32'(outen);
         OFF_INTEN:   rdata = 32'(inten);
         OFF_INTTYPE: rdata = 32'(inttype);
         OFF_INTPOL:  rdata = 32'(intpol);
         OFF_INTBOTH: rdata = 32'(intboth);
         OFF_INTSTAT: rdata = 32'(stat);
         OFF_DBTHR:   rdata = 32'(dbthr);
         OFF_DBEN:    rdata = 32'(dben);
         default:     rdata = '0;
      endcase
   end

   for (genvar g = 0; g < PortWidth; g++) begin : g_pin
      gpio_db_pin #(
         .SyncStages(SyncStages),
         .DbWidth   (DbWidth)
      ) u_pin (
         .clk     (PCLK),
         .rst     (PRESET),
         .pin_in  (PORTIN[g]),
         .db_en   (dben[g]),
         .db_thr  (dbthr),
         .int_en  (inten[g]),
         .int_type(inttype[g]),
         .int_pol (intpol[g]),
         .int_both(intboth[g]),
         .clr     (wr && off == OFF_INTSTAT && wd[g]),
         .stable  (data[g]),
         .stat    (stat[g])
      );
   end
endmodule

// File: tb/tb_apb_gpio_db.sv
// tb_apb_gpio_db: directed scoreboard bench for apb_gpio_db (8-pin and 5-pin builds)
module tb_apb_gpio_db;
   localparam int SS = 2;

   logic        PCLK = 1'b0, PRESET = 1'b1, psel = 1'b0, tgt = 1'b0;
   logic        PENABLE = 1'b0, PWRITE = 1'b0;
   logic [5:0]  PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [7:0]  portin = '0;
   logic [4:0]  portin5 = '0;

   logic [31:0] prdata8, prdata5, prdata;
   logic        pready8, pready5, pready, pslverr8, pslverr5, pslverr;
   logic [7:0]  portout8, porten8, gpioint8;
   logic [4:0]  portout5, porten5, gpioint5;
   logic        combint8, combint5;

   logic [31:0] sb[$];
   int          n_assert = 0, n_fail = 0;

   always #5 PCLK = ~PCLK;

   assign prdata  = tgt ? prdata5 : prdata8;
   assign pready  = tgt ? pready5 : pready8;
   assign pslverr = tgt ? pslverr5 : pslverr8;

   apb_gpio_db #(.PortWidth(8), .SyncStages(SS), .DbWidth(8)) u_dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel & ~tgt), .PADDR(PADDR), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(pslverr8),
      .PORTIN(portin), .PORTOUT(portout8), .PORTEN(porten8), .GPIOINT(gpioint8), .COMBINT(combint8)
   );

   apb_gpio_db #(.PortWidth(5), .SyncStages(SS), .DbWidth(8)) u_dut5 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel & tgt), .PADDR(PADDR), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata5), .PREADY(pready5), .PSLVERR(pslverr5),
      .PORTIN(portin5), .PORTOUT(portout5), .PORTEN(porten5), .GPIOINT(gpioint5), .COMBINT(combint5)
   );

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %0h, nothing queued", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
      end
   endtask

   task automatic expect_now(input string tag, input logic [31:0] exp, input logic [31:0] obs);
      sb.push_back(exp);
      chk(tag, obs);
   endtask

   task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, input logic err);
      @(posedge PCLK); #1;
      psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr[7:2]; PWDATA = data;
      sb.push_back({31'b0, err});
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #2 chk("wr_err", {31'b0, pslverr});
      @(posedge PCLK); #1;
      psel = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] addr, input logic [31:0] exp, input logic err, input string tag);
      @(posedge PCLK); #1;
      psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr[7:2];
      sb.push_back(exp);
      sb.push_back({31'b0, err});
      sb.push_back(32'd1);
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #2;
      chk(tag, prdata);
      chk("rd_err", {31'b0, pslverr});
      chk("pready", {31'b0, pready});
      @(posedge PCLK); #1;
      psel = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      // reset values
      repeat (3) @(posedge PCLK);
      #1 PRESET = 1'b0;
      expect_now("rst_portout", 0, {24'b0, portout8});
      expect_now("rst_porten", 0, {24'b0, porten8});
      expect_now("rst_gpioint", 0, {24'b0, gpioint8});
      expect_now("rst_combint", 0, {31'b0, combint8});
      expect_now("rst_prdata", 0, prdata8);
      expect_now("rst_pslverr", 0, {31'b0, pslverr8});

      // reset asserted for two cycles in the access phase of a DOUT write
      @(posedge PCLK); #1;
      psel = 1'b1; PWRITE = 1'b1; PADDR = 6'h01; PWDATA = 32'hFF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; PRESET = 1'b1;
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1'b0; psel = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      expect_now("midrst_portout", 0, {24'b0, portout8});
      expect_now("midrst_porten", 0, {24'b0, porten8});
      for (int a = 0; a <= 8'h2C; a += 4) apb_read(8'(a), 0, 1'b0, "rst_read");

      // atomic output set/clear
      apb_write(8'h04, 32'h0F, 1'b0);
      expect_now("dout_portout", 32'h0F, {24'b0, portout8});
      apb_write(8'h28, 32'h30, 1'b0);
      expect_now("dset_portout", 32'h3F, {24'b0, portout8});
      apb_write(8'h2C, 32'h03, 1'b0);
      expect_now("dclr_portout", 32'h3C, {24'b0, portout8});
      apb_read(8'h04, 32'h3C, 1'b0, "dout_read");
      apb_write(8'h08, 32'hFF, 1'b0);
      expect_now("outen_porten", 32'hFF, {24'b0, porten8});
      apb_read(8'h28, 0, 1'b0, "dset_read");
      apb_read(8'h2C, 0, 1'b0, "dclr_read");

      // debounce on pin 0, threshold 4
      apb_write(8'h24, 32'h01, 1'b0);
      apb_write(8'h20, 32'h04, 1'b0);
      apb_read(8'h20, 32'h04, 1'b0, "dbthr_read");
      psel = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 6'h00;
      portin[0] = 1'b1;
      repeat (3) @(posedge PCLK);
      #1 portin[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         sb.push_back(0);
         @(posedge PCLK); #1;
         chk("db_glitch", prdata);
      end
      portin[0] = 1'b1;
      for (int k = 1; k <= SS + 5; k++) begin
         sb.push_back(k >= SS + 4 ? 32'd1 : 32'd0);
         @(posedge PCLK); #1;
         chk("db_latency", prdata);
      end
      psel = 1'b0; PENABLE = 1'b0;

      // both-edge interrupt on pin 1 (no debounce)
      apb_write(8'h10, 32'h02, 1'b0);
      apb_write(8'h18, 32'h02, 1'b0);
      apb_write(8'h0C, 32'h02, 1'b0);
      apb_write(8'h1C, 32'hFF, 1'b0);
      apb_read(8'h1C, 0, 1'b0, "edge_pre_stat");
      psel = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 6'h07;
      portin[1] = 1'b1;
      for (int k = 1; k <= SS + 3; k++) begin
         sb.push_back(k >= SS + 2 ? 32'd2 : 32'd0);
         sb.push_back(k >= SS + 3 ? 32'd2 : 32'd0);
         sb.push_back(k >= SS + 3 ? 32'd1 : 32'd0);
         @(posedge PCLK); #1;
         chk("rise_stat", prdata);
         chk("rise_gpioint", {24'b0, gpioint8});
         chk("rise_combint", {31'b0, combint8});
      end
      psel = 1'b0; PENABLE = 1'b0;
      apb_write(8'h1C, 32'h02, 1'b0);
      apb_read(8'h1C, 0, 1'b0, "w1c_stat");
      expect_now("w1c_gpioint", 0, {24'b0, gpioint8});
      expect_now("w1c_combint", 0, {31'b0, combint8});
      // falling edge; W1C commits on the very edge the event is detected
      portin[1] = 1'b0;
      repeat (SS) @(posedge PCLK);
      #1 psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 6'h07; PWDATA = 32'h02;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      psel = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      apb_read(8'h1C, 32'h02, 1'b0, "set_wins_stat");
      expect_now("fall_gpioint", 32'h02, {24'b0, gpioint8});
      expect_now("fall_combint", 1, {31'b0, combint8});

      // high-level interrupt on pin 2
      apb_write(8'h0C, 0, 1'b0);
      apb_write(8'h10, 0, 1'b0);
      apb_write(8'h18, 0, 1'b0);
      apb_write(8'h14, 32'h04, 1'b0);
      portin[2] = 1'b1;
      repeat (5) @(posedge PCLK);
      apb_write(8'h1C, 32'hFF, 1'b0);
      apb_write(8'h0C, 32'h04, 1'b0);
      apb_read(8'h1C, 32'h04, 1'b0, "lvl_stat");
      expect_now("lvl_gpioint", 32'h04, {24'b0, gpioint8});
      apb_write(8'h1C, 32'h04, 1'b0);
      apb_read(8'h1C, 32'h04, 1'b0, "lvl_reset_stat");
      portin[2] = 1'b0;
      repeat (6) @(posedge PCLK);
      apb_read(8'h1C, 32'h04, 1'b0, "lvl_sticky");
      apb_write(8'h0C, 0, 1'b0);
      apb_read(8'h1C, 32'h04, 1'b0, "inten_off_stat");
      expect_now("inten_off_gpioint", 0, {24'b0, gpioint8});
      expect_now("inten_off_combint", 0, {31'b0, combint8});
      apb_write(8'h1C, 32'h04, 1'b0);
      apb_read(8'h1C, 0, 1'b0, "lvl_cleared");

      // unmapped accesses
      apb_write(8'h30, 32'hAA, 1'b1);
      apb_read(8'h04, 32'h3C, 1'b0, "unmapped_wr_noeffect");
      apb_read(8'h30, 0, 1'b1, "unmapped_read");
      apb_read(8'h3C, 0, 1'b1, "unmapped_read_top");

      // 5-pin build: bits above PortWidth read 0
      tgt = 1'b1;
      apb_write(8'h04, 32'hFFFF_FFFF, 1'b0);
      apb_read(8'h04, 32'h1F, 1'b0, "w5_dout");
      expect_now("w5_portout", 32'h1F, {27'b0, portout5});
      expect_now("w5_idle", 0, {27'b0, porten5 | gpioint5} | {31'b0, combint5});
      tgt = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
